// File: rtl/jesd204_tx_lane_monitor.sv
// JESD204 transmit lane monitor: tracks CGS -> ILAS -> DATA progression of one
// lane, checks ILAS multiframe framing and keeps sticky/counting status.
module jesd204_tx_lane_monitor #(
   parameter int unsigned CGS_MIN_BEATS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] phy_data,
   input  logic [3:0]  phy_charisk,
   input  logic [7:0]  cfg_beats_per_multiframe,
   input  logic [7:0]  cfg_mframes_per_ilas,
   output logic [1:0]  status_state,
   output logic        status_ilas_done,
   output logic        status_ilas_error,
   output logic [15:0] status_error_count,
   output logic [31:0] status_data_beats,
   output logic        status_resync
);

   localparam int unsigned CNT_W = (CGS_MIN_BEATS > 1) ? $clog2(CGS_MIN_BEATS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CGS  = 2'd1,
      ST_ILAS = 2'd2,
      ST_DATA = 2'd3
   } state_t;

   state_t        r_state;
   logic [CNT_W-1:0] r_cgs_cnt;
   logic [7:0]    r_beat;
   logic [7:0]    r_mframe;
   logic          r_ilas_done;
   logic          r_ilas_error;
   logic [15:0]   r_error_count;
   logic [31:0]   r_data_beats;
   logic          r_resync;

   logic        w_is_cgs;
   logic        w_is_rstart;
   logic        w_q_ok;
   logic        w_a_ok;
   logic        w_first;
   logic        w_last;
   logic        w_mf_last;
   logic        w_ilas_bad;
   logic [15:0] w_err_inc;

   // Beat classification and ILAS framing checks against the current position
   assign w_is_cgs    = (phy_charisk == 4'hF) && (phy_data == 32'hBCBC_BCBC);
   assign w_is_rstart = phy_charisk[0] && (phy_data[7:0] == 8'h1C);
   assign w_q_ok      = phy_charisk[1] && (phy_data[15:8] == 8'h9C);
   assign w_a_ok      = phy_charisk[3] && (phy_data[31:24] == 8'h7C);
   assign w_first     = (r_beat == 8'd0);
   assign w_last      = (r_beat == cfg_beats_per_multiframe);
   assign w_mf_last   = (r_mframe == cfg_mframes_per_ilas);
   assign w_ilas_bad  = (w_first && !w_is_rstart)
                      || (w_first && (r_mframe == 8'd1) && !w_q_ok)
                      || (w_last && !w_a_ok)
                      || (!w_first && !w_last && (phy_charisk != 4'h0));
   assign w_err_inc   = (r_error_count == 16'hFFFF) ? r_error_count : r_error_count + 16'd1;

   // Lane state machine with registered status
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cgs_cnt     <= '0;
         r_beat        <= 8'd0;
         r_mframe      <= 8'd0;
         r_ilas_done   <= 1'b0;
         r_ilas_error  <= 1'b0;
         r_error_count <= 16'd0;
         r_data_beats  <= 32'd0;
         r_resync      <= 1'b0;
      end else begin
         r_resync <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_is_cgs) begin
                  r_cgs_cnt <= '0;
               end else if (r_cgs_cnt == CNT_W'(CGS_MIN_BEATS - 1)) begin
                  r_cgs_cnt <= '0;
                  r_state   <= ST_CGS;
               end else begin
                  r_cgs_cnt <= r_cgs_cnt + CNT_W'(1);
               end
            end
            ST_CGS: begin
               if (w_is_cgs) begin
                  r_state <= ST_CGS;
               end else if (w_is_rstart) begin
                  // /R/ beat is beat 0 of multiframe 0; with one-beat
                  // multiframes it is also the /A/ beat.
                  if (cfg_beats_per_multiframe != 8'd0) begin
                     r_state  <= ST_ILAS;
                     r_beat   <= 8'd1;
                     r_mframe <= 8'd0;
                  end else if (!w_a_ok) begin
                     r_ilas_error  <= 1'b1;
                     r_error_count <= w_err_inc;
                     r_state       <= ST_IDLE;
                  end else if (cfg_mframes_per_ilas == 8'd0) begin
                     r_ilas_done <= 1'b1;
                     r_state     <= ST_DATA;
                  end else begin
                     r_state  <= ST_ILAS;
                     r_beat   <= 8'd0;
                     r_mframe <= 8'd1;
                  end
               end else begin
                  r_error_count <= w_err_inc;
                  r_state       <= ST_IDLE;
               end
            end
            ST_ILAS: begin
               if (w_ilas_bad) begin
                  r_ilas_error  <= 1'b1;
                  r_error_count <= w_err_inc;
                  r_state       <= ST_IDLE;
               end else if (w_last) begin
                  r_beat <= 8'd0;
                  if (w_mf_last) begin
                     r_ilas_done <= 1'b1;
                     r_state     <= ST_DATA;
                  end else begin
                     r_mframe <= r_mframe + 8'd1;
                  end
               end else begin
                  r_beat <= r_beat + 8'd1;
               end
            end
            ST_DATA: begin
               if (w_is_cgs) begin
                  r_state  <= ST_CGS;
                  r_resync <= 1'b1;
               end else begin
                  r_data_beats <= r_data_beats + 32'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign status_state       = r_state;
   assign status_ilas_done   = r_ilas_done;
   assign status_ilas_error  = r_ilas_error;
   assign status_error_count = r_error_count;
   assign status_data_beats  = r_data_beats;
   assign status_resync      = r_resync;

endmodule

// File: doc/jesd204_tx_lane_monitor.md
JESD204_TX_LANE_MONITOR -- requirements
Module: jesd204_tx_lane_monitor

Interface
REQ-001 SHALL have parameter CGS_MIN_BEATS, default 4, consecutive all-/K/ beats required before CGS lock.
REQ-002 SHALL have a single clock and a synchronous, active-high reset; all state changes on rising edge of clk.
REQ-003 SHALL have port clk  input  1  lane/device clock; one 4-octet beat sampled per cycle.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port phy_data  input  32  lane beat; octet 0 = bits [7:0], first on the wire.
REQ-006 SHALL have port phy_charisk  input  4  per-octet K flag; bit n qualifies octet n.
REQ-007 SHALL have port cfg_beats_per_multiframe  input  8  beats per multiframe minus 1.
REQ-008 SHALL have port cfg_mframes_per_ilas  input  8  ILAS multiframes minus 1.
REQ-009 SHALL have port status_state  output  2  0=IDLE, 1=CGS, 2=ILAS, 3=DATA.
REQ-010 SHALL have port status_ilas_done  output  1  sticky; ILAS completed without error.
REQ-011 SHALL have port status_ilas_error  output  1  sticky; ILAS framing violation seen.
REQ-012 SHALL have port status_error_count  output  16  saturating protocol error count.
REQ-013 SHALL have port status_data_beats  output  32  DATA-state beat count, wraps.
REQ-014 SHALL have port status_resync  output  1  one-cycle pulse on DATA->CGS.

Function
REQ-015 SHALL classify a beat as CGS when phy_charisk=4'hf and phy_data=32'hBCBCBCBC.
REQ-016 SHALL classify a beat as ILAS-start when phy_charisk[0]=1 and phy_data[7:0]=8'h1C (/R/).
REQ-017 IDLE: SHALL count consecutive CGS beats; non-CGS beat clears the count; count reaching CGS_MIN_BEATS -> CGS.
REQ-018 CGS: CGS beat -> stay; ILAS-start -> ILAS with beat counter=1 and mframe counter=0; any other beat -> IDLE and error_count+1.
REQ-019 ILAS: beat counter SHALL run 0..cfg_beats_per_multiframe and wrap to 0, incrementing mframe counter on wrap.
REQ-020 ILAS: beat 0 of every multiframe SHALL have charisk[0]=1, octet0=8'h1C; beat 0 of mframe 1 SHALL additionally have charisk[1]=1, octet1=8'h9C (/Q/).
REQ-021 ILAS: last beat of every multiframe SHALL have charisk[3]=1, octet3=8'h7C (/A/).
REQ-022 ILAS: any other beat SHALL have charisk=4'h0.
REQ-023 ILAS violation SHALL set status_ilas_error, increment error_count, and go to IDLE next cycle.
REQ-024 Last beat of mframe cfg_mframes_per_ilas passing checks SHALL set status_ilas_done and enter DATA.
REQ-025 DATA: each non-CGS beat SHALL increment status_data_beats (wrap 2^32-1 -> 0); a CGS beat SHALL go to CGS, pulse status_resync, and not count.
REQ-026 status_error_count SHALL saturate at 16'hFFFF.
REQ-027 All status outputs SHALL be registered; effect of a beat visible on the cycle after it is sampled.
REQ-028 cfg_* inputs SHALL be treated as static outside reset; behaviour undefined if changed while state is ILAS.
REQ-029 Single-multiframe ILAS (cfg_mframes_per_ilas=0) SHALL skip the /Q/ check; cfg_beats_per_multiframe=0 SHALL apply start and end checks to the same beat.

Reset
REQ-030 Reset SHALL force state IDLE, all counters 0, status_ilas_done=0, status_ilas_error=0, status_resync=0, status_error_count=0, status_data_beats=0.
REQ-031 Reset asserted mid-ILAS or mid-DATA SHALL take priority over any transition that cycle.

Verification
REQ-032 10 CGS beats, ILAS-start, then valid ILAS with cfg_beats=7, cfg_mframes=3 (32 beats) -> state 1 after 4th CGS beat, 2, then 3 with ilas_done=1, error_count=0.
REQ-033 Same as REQ-032 but octet3 of beat 15 = 8'h00 -> ilas_error=1, error_count=1, state 0.
REQ-034 In DATA, 100 data beats then 5 CGS beats -> data_beats=100, single status_resync pulse, state 1.
REQ-035 3 CGS beats, 1 data beat, 4 CGS beats -> state stays 0 until 4th beat of second run, error_count=0.
REQ-036 Force error_count to 16'hFFFE via 3 CGS->garbage sequences after preload -> holds 16'hFFFF.
REQ-037 Reset asserted on ILAS beat 10 -> next cycle all outputs at reset values, state 0.
